// File: rtl/banco_pkg.sv
// Shared types and helpers for the parametrised register bank.
package banco_pkg;

    // Clear-sweep state machine states.
    typedef enum logic {
        OCIOSO   = 1'b0,
        VARRENDO = 1'b1
    } estado_t;

    // Address width for a bank of num_regs registers, never below one bit.
    function automatic int unsigned calc_end(input int unsigned num_regs);
        int unsigned bits;
        bits = unsigned'($clog2(num_regs));
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/banco_registradores_param_if.sv
// Read/write/clear bus of the register bank; the bank is the slave side.
interface banco_registradores_param_if
    import banco_pkg::*;
#(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned NUM_LEITURAS = 2,
    parameter int unsigned END          = calc_end(32)
);

    logic [NUM_LEITURAS*END-1:0]     reg_a_ser_lido;
    logic [NUM_LEITURAS*LARGURA-1:0] dado_lido;
    logic                            esc_reg;
    logic [END-1:0]                  reg_a_ser_escrito;
    logic [LARGURA-1:0]              dado_de_escrita;
    logic                            limpar;
    logic                            ocupado;

    modport master (
        output reg_a_ser_lido,
        output esc_reg,
        output reg_a_ser_escrito,
        output dado_de_escrita,
        output limpar,
        input  dado_lido,
        input  ocupado
    );

    modport slave (
        input  reg_a_ser_lido,
        input  esc_reg,
        input  reg_a_ser_escrito,
        input  dado_de_escrita,
        input  limpar,
        output dado_lido,
        output ocupado
    );

endinterface

// File: rtl/porta_leitura.sv
// One combinational read port: range check, register-0 masking and write bypass.
module porta_leitura #(
    parameter int unsigned LARGURA  = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned END      = 5,
    parameter bit          R0_ZERO  = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [END-1:0]     i_end,
    input  logic [LARGURA-1:0] i_banco [NUM_REGS],
    input  logic               i_esc_valido,
    input  logic [END-1:0]     i_end_esc,
    input  logic [LARGURA-1:0] i_dado_esc,
    output logic [LARGURA-1:0] o_dado
);

    localparam logic [END:0] L_NUM_REGS = (END+1)'(NUM_REGS);

    logic               w_na_faixa;
    logic               w_zero;
    logic               w_bypass;
    logic [LARGURA-1:0] w_reg;

    // Extra MSB so NUM_REGS itself is representable when it is a power of two.
    assign w_na_faixa = ({1'b0, i_end} < L_NUM_REGS);
    assign w_zero     = R0_ZERO && (i_end == '0);
    // i_esc_valido already excludes sweeps, out-of-range and R0 writes.
    assign w_bypass   = BYPASS && i_esc_valido && (i_end == i_end_esc);

    // Array mux by equality so non-power-of-two banks never index past the end.
    always_comb begin
        w_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_end == END'(i)) begin
                w_reg = i_banco[i];
            end
        end
    end

    // Final selection, priority: out of range / R0, then bypass, then array.
    always_comb begin
        if (!w_na_faixa || w_zero) begin
            o_dado = '0;
        end else if (w_bypass) begin
            o_dado = i_dado_esc;
        end else begin
            o_dado = w_reg;
        end
    end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank with synchronous writes, combinational reads
// and a sequenced whole-bank clear.
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned NUM_LEITURAS = 2,
    parameter bit          R0_ZERO      = 1'b1,
    parameter bit          BYPASS       = 1'b1
) (
    input logic                         clock,
    input logic                         reset,
    banco_registradores_param_if.slave  bus
);

    localparam int unsigned  END        = calc_end(NUM_REGS);
    localparam logic [END:0] L_NUM_REGS = (END+1)'(NUM_REGS);
    localparam logic [END:0] L_ULTIMO   = (END+1)'(NUM_REGS - 1);

    estado_t                         r_estado;
    logic                            r_ocupado;
    logic [END:0]                    r_contador;
    logic [LARGURA-1:0]              r_banco [NUM_REGS];
    logic                            w_esc_valido;
    logic [NUM_LEITURAS*LARGURA-1:0] w_dado_lido;

    // A write takes effect only when idle, in range and not aimed at a hard-wired R0.
    assign w_esc_valido = bus.esc_reg && !r_ocupado &&
                          ({1'b0, bus.reg_a_ser_escrito} < L_NUM_REGS) &&
                          !(R0_ZERO && (bus.reg_a_ser_escrito == '0));

    // Clear FSM: sweep one register per cycle, ocupado registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_ocupado  <= 1'b0;
            r_contador <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (bus.limpar) begin
                        r_estado   <= VARRENDO;
                        r_ocupado  <= 1'b1;
                        r_contador <= '0;
                    end
                end
                VARRENDO: begin
                    if (r_contador == L_ULTIMO) begin
                        r_estado   <= OCIOSO;
                        r_ocupado  <= 1'b0;
                        r_contador <= '0;
                    end else begin
                        r_contador <= r_contador + 1'b1;
                    end
                end
                default: begin
                    r_estado   <= OCIOSO;
                    r_ocupado  <= 1'b0;
                    r_contador <= '0;
                end
            endcase
        end
    end

    // Register array: the sweep clear has priority; writes are blocked while sweeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_banco[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((r_estado == VARRENDO) && (r_contador == (END+1)'(i))) begin
                    r_banco[i] <= '0;
                end else if (w_esc_valido && (bus.reg_a_ser_escrito == END'(i))) begin
                    r_banco[i] <= bus.dado_de_escrita;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_LEITURAS; k++) begin : g_porta
        porta_leitura #(
            .LARGURA  (LARGURA),
            .NUM_REGS (NUM_REGS),
            .END      (END),
            .R0_ZERO  (R0_ZERO),
            .BYPASS   (BYPASS)
        ) u_porta (
            .i_end        (bus.reg_a_ser_lido[k*END +: END]),
            .i_banco      (r_banco),
            .i_esc_valido (w_esc_valido),
            .i_end_esc    (bus.reg_a_ser_escrito),
            .i_dado_esc   (bus.dado_de_escrita),
            .o_dado       (w_dado_lido[k*LARGURA +: LARGURA])
        );
    end

    assign bus.dado_lido = w_dado_lido;
    assign bus.ocupado   = r_ocupado;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench for banco_registradores_param: default bank with bypass,
// a mirrored bank without bypass, and a 20x8-bit three-port bank.
module tb_banco_registradores_param;
    import banco_pkg::*;

    localparam int unsigned END_A = calc_end(32);
    localparam int unsigned END_C = calc_end(20);

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n;

    banco_registradores_param_if #(.LARGURA(32), .NUM_LEITURAS(2), .END(END_A)) bus_a ();
    banco_registradores_param_if #(.LARGURA(32), .NUM_LEITURAS(2), .END(END_A)) bus_b ();
    banco_registradores_param_if #(.LARGURA(8),  .NUM_LEITURAS(3), .END(END_C)) bus_c ();

    // Bank B sees exactly the stimulus of bank A.
    assign bus_b.reg_a_ser_lido    = bus_a.reg_a_ser_lido;
    assign bus_b.esc_reg           = bus_a.esc_reg;
    assign bus_b.reg_a_ser_escrito = bus_a.reg_a_ser_escrito;
    assign bus_b.dado_de_escrita   = bus_a.dado_de_escrita;
    assign bus_b.limpar            = bus_a.limpar;

    banco_registradores_param #(
        .LARGURA(32), .NUM_REGS(32), .NUM_LEITURAS(2), .R0_ZERO(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    banco_registradores_param #(
        .LARGURA(32), .NUM_REGS(32), .NUM_LEITURAS(2), .R0_ZERO(1'b1), .BYPASS(1'b0)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    banco_registradores_param #(
        .LARGURA(8), .NUM_REGS(20), .NUM_LEITURAS(3), .R0_ZERO(1'b1), .BYPASS(1'b1)
    ) dut_c (
        .clock (clock),
        .reset (reset),
        .bus   (bus_c)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Single write on bank A (and B): drive, take one edge, release.
    task automatic escreve_a(input logic [4:0] ender, input logic [31:0] dado);
        bus_a.esc_reg           = 1'b1;
        bus_a.reg_a_ser_escrito = ender;
        bus_a.dado_de_escrita   = dado;
        @(posedge clock); #1;
        bus_a.esc_reg = 1'b0;
    endtask

    task automatic escreve_c(input logic [4:0] ender, input logic [7:0] dado);
        bus_c.esc_reg           = 1'b1;
        bus_c.reg_a_ser_escrito = ender;
        bus_c.dado_de_escrita   = dado;
        @(posedge clock); #1;
        bus_c.esc_reg = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus_a.reg_a_ser_lido    = '0;
        bus_a.esc_reg           = 1'b0;
        bus_a.reg_a_ser_escrito = '0;
        bus_a.dado_de_escrita   = '0;
        bus_a.limpar            = 1'b0;
        bus_c.reg_a_ser_lido    = '0;
        bus_c.esc_reg           = 1'b0;
        bus_c.reg_a_ser_escrito = '0;
        bus_c.dado_de_escrita   = '0;
        bus_c.limpar            = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_dado_a", 64'(bus_a.dado_lido), 64'h0);
        check_eq("reset_ocupado_a", 64'(bus_a.ocupado), 64'h0);
        check_eq("reset_ocupado_c", 64'(bus_c.ocupado), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            bus_a.reg_a_ser_lido = {5'(31 - i), 5'(i)};
            #1;
            check_eq("reset_le_p0", 64'(bus_a.dado_lido[31:0]), 64'h0);
            check_eq("reset_le_p1", 64'(bus_a.dado_lido[63:32]), 64'h0);
        end

        // Write R5 with and without bypass
        @(posedge clock); #1;
        bus_a.reg_a_ser_lido    = {5'd5, 5'd5};
        bus_a.esc_reg           = 1'b1;
        bus_a.reg_a_ser_escrito = 5'd5;
        bus_a.dado_de_escrita   = 32'hDEADBEEF;
        #1;
        check_eq("bypass_r5_a", 64'(bus_a.dado_lido[31:0]), 64'hDEADBEEF);
        check_eq("sem_bypass_r5_b", 64'(bus_b.dado_lido[31:0]), 64'h0);
        @(posedge clock); #1;
        bus_a.esc_reg = 1'b0;
        #1;
        check_eq("le_r5_p0_a", 64'(bus_a.dado_lido[31:0]), 64'hDEADBEEF);
        check_eq("le_r5_p1_a", 64'(bus_a.dado_lido[63:32]), 64'hDEADBEEF);
        check_eq("le_r5_p0_b", 64'(bus_b.dado_lido[31:0]), 64'hDEADBEEF);

        // R0 hard-wired to zero, no bypass either
        bus_a.reg_a_ser_lido    = {5'd5, 5'd0};
        bus_a.esc_reg           = 1'b1;
        bus_a.reg_a_ser_escrito = 5'd0;
        bus_a.dado_de_escrita   = 32'h1234;
        #1;
        check_eq("r0_sem_bypass", 64'(bus_a.dado_lido[31:0]), 64'h0);
        @(posedge clock); #1;
        bus_a.esc_reg = 1'b0;
        #1;
        check_eq("r0_zero_a", 64'(bus_a.dado_lido[31:0]), 64'h0);
        check_eq("r0_zero_b", 64'(bus_b.dado_lido[31:0]), 64'h0);

        // Load R1..R31 with their index, then sweep
        for (int i = 1; i < 32; i++) begin
            escreve_a(5'(i), 32'(i));
        end
        bus_a.reg_a_ser_lido = {5'd20, 5'd5};
        #1;
        check_eq("carga_r5", 64'(bus_a.dado_lido[31:0]), 64'd5);
        check_eq("carga_r20", 64'(bus_a.dado_lido[63:32]), 64'd20);

        bus_a.reg_a_ser_lido = {5'd20, 5'd9};
        check_eq("pre_limpar_ocupado", 64'(bus_a.ocupado), 64'h0);
        bus_a.limpar = 1'b1;
        @(posedge clock); #1;
        bus_a.limpar = 1'b0;
        check_eq("limpar_ocupado_sobe", 64'(bus_a.ocupado), 64'h1);
        n = 0;
        while ((bus_a.ocupado === 1'b1) && (n < 100)) begin
            if (n == 10) begin
                check_eq("varre10_r9", 64'(bus_a.dado_lido[31:0]), 64'h0);
                check_eq("varre10_r20", 64'(bus_a.dado_lido[63:32]), 64'd20);
                bus_a.reg_a_ser_lido    = {5'd31, 5'd9};
                bus_a.esc_reg           = 1'b1;
                bus_a.reg_a_ser_escrito = 5'd31;
                bus_a.dado_de_escrita   = 32'h55;
                #1;
                check_eq("varre_sem_bypass_r31", 64'(bus_a.dado_lido[63:32]), 64'd31);
            end
            if (n == 11) begin
                bus_a.esc_reg = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        check_eq("duracao_ocupado_a", 64'(n), 64'd32);
        check_eq("duracao_ocupado_b", 64'(bus_b.ocupado), 64'h0);
        bus_a.reg_a_ser_lido = {5'd31, 5'd20};
        #1;
        check_eq("pos_varre_r20", 64'(bus_a.dado_lido[31:0]), 64'h0);
        check_eq("pos_varre_r31", 64'(bus_a.dado_lido[63:32]), 64'h0);
        check_eq("pos_varre_r31_b", 64'(bus_b.dado_lido[63:32]), 64'h0);

        // First write after the sweep is accepted
        escreve_a(5'd7, 32'h77);
        bus_a.reg_a_ser_lido = {5'd7, 5'd7};
        #1;
        check_eq("escrita_pos_varre", 64'(bus_a.dado_lido[31:0]), 64'h77);

        // Reset during a sweep
        escreve_a(5'd15, 32'hAA);
        bus_a.reg_a_ser_lido = {5'd7, 5'd15};
        bus_a.limpar = 1'b1;
        @(posedge clock); #1;
        bus_a.limpar = 1'b0;
        repeat (7) begin
            @(posedge clock); #1;
        end
        check_eq("varre7_r15", 64'(bus_a.dado_lido[31:0]), 64'hAA);
        check_eq("varre7_ocupado", 64'(bus_a.ocupado), 64'h1);
        reset = 1'b1;
        #1;
        check_eq("reset_meio_ocupado", 64'(bus_a.ocupado), 64'h0);
        check_eq("reset_meio_r15", 64'(bus_a.dado_lido[31:0]), 64'h0);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("pos_reset_ocioso", 64'(bus_a.ocupado), 64'h0);
        escreve_a(5'd3, 32'h33);
        bus_a.reg_a_ser_lido = {5'd3, 5'd15};
        #1;
        check_eq("pos_reset_escrita", 64'(bus_a.dado_lido[63:32]), 64'h33);
        check_eq("pos_reset_r15", 64'(bus_a.dado_lido[31:0]), 64'h0);

        // 20-register, 8-bit, 3-port bank
        bus_c.reg_a_ser_lido    = {5'd0, 5'd0, 5'd25};
        bus_c.esc_reg           = 1'b1;
        bus_c.reg_a_ser_escrito = 5'd25;
        bus_c.dado_de_escrita   = 8'h5A;
        #1;
        check_eq("c_fora_bypass", 64'(bus_c.dado_lido[7:0]), 64'h0);
        @(posedge clock); #1;
        bus_c.esc_reg = 1'b0;
        #1;
        check_eq("c_fora_le", 64'(bus_c.dado_lido[7:0]), 64'h0);
        escreve_c(5'd19, 8'hC3);
        bus_c.reg_a_ser_lido    = {5'd19, 5'd4, 5'd25};
        bus_c.esc_reg           = 1'b1;
        bus_c.reg_a_ser_escrito = 5'd4;
        bus_c.dado_de_escrita   = 8'h4E;
        #1;
        check_eq("c_r19_p2", 64'(bus_c.dado_lido[23:16]), 64'hC3);
        check_eq("c_bypass_r4", 64'(bus_c.dado_lido[15:8]), 64'h4E);
        check_eq("c_fora_p0", 64'(bus_c.dado_lido[7:0]), 64'h0);
        @(posedge clock); #1;
        bus_c.esc_reg = 1'b0;
        bus_c.limpar  = 1'b1;
        #1;
        check_eq("c_r4", 64'(bus_c.dado_lido[15:8]), 64'h4E);
        @(posedge clock); #1;
        bus_c.limpar = 1'b0;
        n = 0;
        while ((bus_c.ocupado === 1'b1) && (n < 100)) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("c_duracao_ocupado", 64'(n), 64'd20);
        check_eq("c_pos_varre_r19", 64'(bus_c.dado_lido[23:16]), 64'h0);
        check_eq("c_pos_varre_r4", 64'(bus_c.dado_lido[15:8]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
